// File: rtl/riscv_pkg.sv
// Shared constants and types for the integer pipeline: datapath widths,
// ALU operation encodings and the ID/EX operand bundle layout.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            mem_read;
        logic [OP_W-1:0] alu_op;
    } operand_bundle_t;

    localparam int BUNDLE_W = $bits(operand_bundle_t);

endpackage

// File: rtl/operand_bypass.sv
// Per-operand source select: x0 reads as zero, then EX result, then the
// in-flight WB write, and finally the register file.
module operand_bypass
    import riscv_pkg::*;
(
    input  logic [RA_W-1:0] idx,
    input  logic [XLEN-1:0] rf_data,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [XLEN-1:0] ex_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand
);

    // A load in EX has no data yet, so it never forwards; the stall covers it.
    always_comb begin
        operand = rf_data;
        if (idx == '0) begin
            operand = '0;
        end else if (ex_reg_write && !ex_mem_read && (ex_rd == idx)) begin
            operand = ex_result;
        end else if (wb_reg_write && (wb_rd == idx)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// ID/EX boundary: register-file read addressing, EX/WB bypass, load-use
// stall and a ready/valid registered operand bundle for execute.
module operand_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic [XLEN-1:0] in_imm,
    input  logic [OP_W-1:0] in_alu_op,
    output logic [RA_W-1:0] rf_rs1,
    output logic [RA_W-1:0] rf_rs2,
    input  logic [XLEN-1:0] rf_data1,
    input  logic [XLEN-1:0] rf_data2,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [XLEN-1:0] ex_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [RA_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic [OP_W-1:0] out_alu_op
);

    logic [XLEN-1:0] fwd_op1;
    logic [XLEN-1:0] fwd_op2;
    logic            load_use;
    logic            adv;
    logic            valid_q;
    operand_bundle_t bundle_q;

    assign rf_rs1 = in_rs1;
    assign rf_rs2 = in_rs2;

    operand_bypass u_bypass_op1 (
        .idx          (in_rs1),
        .rf_data      (rf_data1),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_result    (ex_result),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data),
        .operand      (fwd_op1)
    );

    operand_bypass u_bypass_op2 (
        .idx          (in_rs2),
        .rf_data      (rf_data2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_result    (ex_result),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data),
        .operand      (fwd_op2)
    );

    // Only sources the instruction actually reads can trigger the stall.
    assign load_use = in_valid && ex_reg_write && ex_mem_read && (ex_rd != '0) &&
                      ((in_use_rs1 && (ex_rd == in_rs1)) ||
                       (in_use_rs2 && (ex_rd == in_rs2)));

    assign adv      = !valid_q || out_ready;
    assign in_ready = flush || (adv && !load_use);

    // Flush outranks everything; a held bundle keeps its fields untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (adv && in_valid && !load_use) begin
            valid_q            <= 1'b1;
            bundle_q.pc        <= in_pc;
            bundle_q.op1       <= fwd_op1;
            bundle_q.op2       <= fwd_op2;
            bundle_q.imm       <= in_imm;
            bundle_q.rd        <= in_rd;
            bundle_q.reg_write <= in_reg_write;
            bundle_q.mem_read  <= in_mem_read;
            bundle_q.alu_op    <= in_alu_op;
        end else if (adv) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = bundle_q.pc;
    assign out_op1       = bundle_q.op1;
    assign out_op2       = bundle_q.op2;
    assign out_imm       = bundle_q.imm;
    assign out_rd        = bundle_q.rd;
    assign out_reg_write = bundle_q.reg_write;
    assign out_mem_read  = bundle_q.mem_read;
    assign out_alu_op    = bundle_q.alu_op;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: expected bundles are queued when an
// instruction is accepted and compared when the stage presents them.
module tb_operand_stage;
    import riscv_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [RA_W-1:0] in_rs1;
    logic [RA_W-1:0] in_rs2;
    logic            in_use_rs1;
    logic            in_use_rs2;
    logic [RA_W-1:0] in_rd;
    logic            in_reg_write;
    logic            in_mem_read;
    logic [XLEN-1:0] in_imm;
    logic [OP_W-1:0] in_alu_op;
    logic [RA_W-1:0] rf_rs1;
    logic [RA_W-1:0] rf_rs2;
    logic [XLEN-1:0] rf_data1;
    logic [XLEN-1:0] rf_data2;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic [XLEN-1:0] ex_result;
    logic [RA_W-1:0] wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [XLEN-1:0] out_imm;
    logic [RA_W-1:0] out_rd;
    logic            out_reg_write;
    logic            out_mem_read;
    logic [OP_W-1:0] out_alu_op;

    int tests_run;
    int tests_failed;
    operand_bundle_t sb[$];
    operand_bundle_t exp_b;
    operand_bundle_t got_b;

    operand_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_use_rs1    (in_use_rs1),
        .in_use_rs2    (in_use_rs2),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_mem_read   (in_mem_read),
        .in_imm        (in_imm),
        .in_alu_op     (in_alu_op),
        .rf_rs1        (rf_rs1),
        .rf_rs2        (rf_rs2),
        .rf_data1      (rf_data1),
        .rf_data2      (rf_data2),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_result     (ex_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_op1       (out_op1),
        .out_op2       (out_op2),
        .out_imm       (out_imm),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_alu_op    (out_alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid     = 1'b0;
        in_pc        = '0;
        in_rs1       = '0;
        in_rs2       = '0;
        in_use_rs1   = 1'b0;
        in_use_rs2   = 1'b0;
        in_rd        = '0;
        in_reg_write = 1'b0;
        in_mem_read  = 1'b0;
        in_imm       = '0;
        in_alu_op    = ALU_ADD;
        rf_data1     = '0;
        rf_data2     = '0;
        ex_rd        = '0;
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        ex_result    = '0;
        wb_rd        = '0;
        wb_reg_write = 1'b0;
        wb_data      = '0;
        flush        = 1'b0;
        out_ready    = 1'b1;
    endtask

    task automatic drive_instr(input logic [XLEN-1:0] pc, input logic [RA_W-1:0] rs1,
                               input logic [RA_W-1:0] rs2, input logic [RA_W-1:0] rd,
                               input logic [XLEN-1:0] imm, input logic [OP_W-1:0] op);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_use_rs1   = 1'b1;
        in_use_rs2   = 1'b1;
        in_rd        = rd;
        in_reg_write = 1'b1;
        in_mem_read  = 1'b0;
        in_imm       = imm;
        in_alu_op    = op;
    endtask

    function automatic operand_bundle_t make_exp(input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] op1,
                                                 input logic [XLEN-1:0] op2,
                                                 input logic [XLEN-1:0] imm,
                                                 input logic [RA_W-1:0] rd,
                                                 input logic [OP_W-1:0] op);
        operand_bundle_t b;
        b.pc        = pc;
        b.op1       = op1;
        b.op2       = op2;
        b.imm       = imm;
        b.rd        = rd;
        b.reg_write = 1'b1;
        b.mem_read  = 1'b0;
        b.alu_op    = op;
        return b;
    endfunction

    function automatic operand_bundle_t observed();
        operand_bundle_t b;
        b.pc        = out_pc;
        b.op1       = out_op1;
        b.op2       = out_op2;
        b.imm       = out_imm;
        b.rd        = out_rd;
        b.reg_write = out_reg_write;
        b.mem_read  = out_mem_read;
        b.alu_op    = out_alu_op;
        return b;
    endfunction

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
        end
        got_b = observed();
        tests_run++;
        if (got_b !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_fields: got %h expected 0", got_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_plain_read();
        drive_instr(32'h100, 5'd1, 5'd2, 5'd3, 32'h4, ALU_ADD);
        rf_data1 = 32'h11;
        rf_data2 = 32'h22;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || rf_rs1 !== 5'd1 || rf_rs2 !== 5'd2) begin
            tests_failed++;
            $display("[TB] FAIL plain_accept: got ready=%b rs1=%0d rs2=%0d expected 1/1/2",
                     in_ready, rf_rs1, rf_rs2);
        end
        sb.push_back(make_exp(32'h100, 32'h11, 32'h22, 32'h4, 5'd3, ALU_ADD));
        step();
        drive_idle();
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL plain_valid: got %b expected 1", out_valid);
        end else begin
            exp_b = sb.pop_front();
            got_b = observed();
            if (got_b !== exp_b) begin
                tests_failed++;
                $display("[TB] FAIL plain_bundle: got %h expected %h", got_b, exp_b);
            end
        end
    endtask

    task automatic test_ex_bypass();
        drive_instr(32'h104, 5'd5, 5'd6, 5'd8, 32'hFFFF_FFF0, ALU_SUB);
        rf_data1     = 32'hAAAA;
        rf_data2     = 32'h66;
        ex_rd        = 5'd5;
        ex_reg_write = 1'b1;
        ex_result    = 32'hDEAD;
        wb_rd        = 5'd5;
        wb_reg_write = 1'b1;
        wb_data      = 32'hBEEF;
        sb.push_back(make_exp(32'h104, 32'hDEAD, 32'h66, 32'hFFFF_FFF0, 5'd8, ALU_SUB));
        step();
        drive_idle();
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL ex_bypass_valid: got %b expected 1", out_valid);
        end else begin
            exp_b = sb.pop_front();
            got_b = observed();
            if (got_b !== exp_b) begin
                tests_failed++;
                $display("[TB] FAIL ex_bypass: got %h expected %h", got_b, exp_b);
            end
        end
    endtask

    task automatic test_wb_bypass_x0();
        drive_instr(32'h108, 5'd0, 5'd7, 5'd9, 32'h8, ALU_XOR);
        rf_data1     = 32'h99;
        rf_data2     = 32'h0;
        ex_rd        = 5'd0;
        ex_reg_write = 1'b1;
        ex_result    = 32'h5;
        wb_rd        = 5'd7;
        wb_reg_write = 1'b1;
        wb_data      = 32'h1234;
        sb.push_back(make_exp(32'h108, 32'h0, 32'h1234, 32'h8, 5'd9, ALU_XOR));
        step();
        drive_idle();
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL wb_x0_valid: got %b expected 1", out_valid);
        end else begin
            exp_b = sb.pop_front();
            got_b = observed();
            if (got_b !== exp_b) begin
                tests_failed++;
                $display("[TB] FAIL wb_x0_bundle: got %h expected %h", got_b, exp_b);
            end
        end
    endtask

    task automatic test_load_use();
        drive_instr(32'h10C, 5'd1, 5'd3, 5'd10, 32'h0, ALU_OR);
        rf_data1     = 32'h10;
        rf_data2     = 32'h0;
        ex_rd        = 5'd3;
        ex_reg_write = 1'b1;
        ex_mem_read  = 1'b1;
        ex_result    = 32'hBAD0;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_use_ready: got %b expected 0", in_ready);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_use_bubble: got %b expected 0", out_valid);
        end
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        ex_rd        = 5'd0;
        wb_rd        = 5'd3;
        wb_reg_write = 1'b1;
        wb_data      = 32'h77;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_use_release: got %b expected 1", in_ready);
        end
        sb.push_back(make_exp(32'h10C, 32'h10, 32'h77, 32'h0, 5'd10, ALU_OR));
        step();
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL load_use_valid: got %b expected 1", out_valid);
        end else begin
            exp_b = sb.pop_front();
            got_b = observed();
            if (got_b !== exp_b) begin
                tests_failed++;
                $display("[TB] FAIL load_use_bundle: got %h expected %h", got_b, exp_b);
            end
        end
        drive_instr(32'h110, 5'd1, 5'd3, 5'd11, 32'h0, ALU_AND);
        in_use_rs2   = 1'b0;
        rf_data1     = 32'h10;
        rf_data2     = 32'h33;
        ex_rd        = 5'd3;
        ex_reg_write = 1'b1;
        ex_mem_read  = 1'b1;
        ex_result    = 32'hBAD0;
        wb_reg_write = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL unused_src_ready: got %b expected 1", in_ready);
        end
        sb.push_back(make_exp(32'h110, 32'h10, 32'h33, 32'h0, 5'd11, ALU_AND));
        step();
        drive_idle();
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unused_src_valid: got %b expected 1", out_valid);
        end else begin
            exp_b = sb.pop_front();
            got_b = observed();
            if (got_b !== exp_b) begin
                tests_failed++;
                $display("[TB] FAIL unused_src_bundle: got %h expected %h", got_b, exp_b);
            end
        end
    endtask

    task automatic test_backpressure();
        drive_instr(32'h200, 5'd1, 5'd2, 5'd12, 32'h1, ALU_SLT);
        rf_data1 = 32'hA1;
        rf_data2 = 32'hA2;
        sb.push_back(make_exp(32'h200, 32'hA1, 32'hA2, 32'h1, 5'd12, ALU_SLT));
        step();
        drive_instr(32'h204, 5'd4, 5'd5, 5'd13, 32'h2, ALU_SLL);
        rf_data1  = 32'hB4;
        rf_data2  = 32'hB5;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL hold_ready[%0d]: got %b expected 0", i, in_ready);
            end
            step();
            got_b = observed();
            tests_run++;
            if (out_valid !== 1'b1 || sb.size() == 0 || got_b !== sb[0]) begin
                tests_failed++;
                $display("[TB] FAIL hold_bundle[%0d]: got v=%b %h expected v=1 held bundle",
                         i, out_valid, got_b);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hold_release_ready: got %b expected 1", in_ready);
        end
        if (sb.size() != 0) void'(sb.pop_front());
        sb.push_back(make_exp(32'h204, 32'hB4, 32'hB5, 32'h2, 5'd13, ALU_SLL));
        step();
        drive_idle();
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_valid: got %b expected 1", out_valid);
        end else begin
            exp_b = sb.pop_front();
            got_b = observed();
            if (got_b !== exp_b) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back_bundle: got %h expected %h", got_b, exp_b);
            end
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_bubble: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        drive_instr(32'h300, 5'd1, 5'd2, 5'd14, 32'h3, ALU_SRA);
        rf_data1 = 32'hC1;
        rf_data2 = 32'hC2;
        sb.push_back(make_exp(32'h300, 32'hC1, 32'hC2, 32'h3, 5'd14, ALU_SRA));
        step();
        drive_instr(32'h304, 5'd4, 5'd2, 5'd15, 32'h0, ALU_ADD);
        ex_rd        = 5'd4;
        ex_reg_write = 1'b1;
        ex_mem_read  = 1'b1;
        out_ready    = 1'b0;
        flush        = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_ready: got %b expected 1", in_ready);
        end
        if (sb.size() != 0) void'(sb.pop_front());
        step();
        drive_idle();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_hold();
        drive_instr(32'h400, 5'd1, 5'd2, 5'd16, 32'h5, ALU_SRL);
        rf_data1 = 32'hD1;
        rf_data2 = 32'hD2;
        sb.push_back(make_exp(32'h400, 32'hD1, 32'hD2, 32'h5, 5'd16, ALU_SRL));
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0 || observed() !== sb[0]) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_hold: got v=%b %h expected v=1 captured bundle",
                     out_valid, observed());
        end
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        tests_run++;
        if (out_valid !== 1'b0 || out_op1 !== '0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got v=%b op1=%h expected v=0 op1=0",
                     out_valid, out_op1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        step();
        tests_run++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL final_drain: got pending=%0d v=%b expected 0/0",
                     sb.size(), out_valid);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_plain_read();
        test_ex_bypass();
        test_wb_bypass_x0();
        test_load_use();
        test_backpressure();
        test_flush();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- ID/EX boundary stage.
- Drives rs1/rs2 read addresses into the 32x32 register file (combinational read; write commits on the clk edge).
- Resolves RAW hazards by bypassing EX and WB results, and stalls one cycle on load-use.
- Registers a ready/valid operand bundle for the ALU/execute stage.

Parameters:
XLEN, 32, data width
RA_W, 5, register address width
OP_W, 4, ALU operation code width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts decoded instruction this cycle
in_pc  in  XLEN  instruction PC
in_rs1 / in_rs2  in  RA_W  source register indices
in_use_rs1 / in_use_rs2  in  1  source actually read by instruction
in_rd  in  RA_W  destination index
in_reg_write  in  1  instruction writes rd
in_mem_read  in  1  instruction is a load
in_imm  in  XLEN  sign-extended immediate
in_alu_op  in  OP_W  ALU operation
rf_rs1 / rf_rs2  out  RA_W  register-file read addresses (= in_rs1/in_rs2, combinational)
rf_data1 / rf_data2  in  XLEN  register-file read data
ex_rd, ex_reg_write, ex_mem_read, ex_result  in  RA_W,1,1,XLEN  instruction currently in EX
wb_rd, wb_reg_write, wb_data  in  RA_W,1,XLEN  write in progress to register file
flush  in  1  kill instruction in this stage (branch redirect)
out_valid  out  1  operand bundle valid
out_ready  in  1  execute stage accepts bundle
out_pc, out_op1, out_op2, out_imm, out_rd, out_reg_write, out_mem_read, out_alu_op  out  as inputs  registered bundle

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all out_* data fields=0. Release is synchronous to clk.
- Bypass, per operand, highest priority first:
  - index==0 -> 0.
  - ex_reg_write && !ex_mem_read && ex_rd==idx -> ex_result.
  - wb_reg_write && wb_rd==idx -> wb_data. This covers the write not yet visible in the register file this cycle.
  - Otherwise rf_data.
- load_use = in_valid && ex_reg_write && ex_mem_read && ex_rd!=0 && ((in_use_rs1 && ex_rd==in_rs1) || (in_use_rs2 && ex_rd==in_rs2)).
- adv = !out_valid || out_ready.
- in_ready = flush || (adv && !load_use). This is combinational.
- Output register update at posedge clk:
  - flush: out_valid<=0. The incoming instruction is consumed and discarded.
  - else adv && in_valid && !load_use: capture the bundle, out_valid<=1. Latency is 1 cycle.
  - else adv: out_valid<=0 (bubble; load_use inserts exactly one bubble per EX load).
  - else (out_valid && !out_ready): hold all out_* stable.
- out_* data fields are don't-care when out_valid=0 but do not toggle during a hold.
- Unused sources (use_rs=0) never stall. Forwarded data for them is still muxed but irrelevant.
- Simultaneous EX and WB match on the same index: EX wins (younger).
- flush while a load_use is pending: flush wins, no stall.
- Reset asserted mid-transfer: bundle lost, out_valid=0 immediately (async).

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and RA_W constants.
  - ALU op encoding constants (OP_W wide).
  - Operand-bundle field widths.
- One sub-module, operand_bypass: the combinational 3-source mux plus x0 handling. It is instantiated twice (op1, op2).
- The hazard detect and output register stay in operand_stage.

Test Plan:
- Plain read: rf_data1=0x11, rf_data2=0x22, no matches, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_op1=0x11, out_op2=0x22.
- EX bypass: in_rs1=5, ex_rd=5, ex_reg_write=1, ex_mem_read=0, ex_result=0xDEAD, wb_rd=5, wb_data=0xBEEF -> out_op1=0xDEAD.
- WB bypass and x0:
  - in_rs2=7, wb_rd=7, wb_data=0x1234, rf_data2=0 -> out_op2=0x1234.
  - in_rs1=0, ex_rd=0, ex_result=0x5 -> out_op1=0.
- Load-use: ex_mem_read=1, ex_rd=3, in_rs2=3, in_use_rs2=1 -> in_ready=0 and one bubble (out_valid=0). Next cycle (EX clear, WB forwards 0x77) -> accepted, out_op2=0x77. With in_use_rs2=0 -> no stall.
- Backpressure/flush:
  - out_ready=0 for 3 cycles -> out_* held, in_ready=0.
  - flush=1 with in_valid=1 -> in_ready=1, next out_valid=0.
  - rst_n pulled low mid-hold -> out_valid=0 before next edge.
